// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder model.
// Used by mem_responder and, when MEM_RANDOM_LATENCY_EN is defined, mem_lfsr.
package mem_pkg;
    localparam int          LINE_W     = 128;
    localparam int          MEM_ADDR_W = 28;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;
endpackage

// File: rtl/mem_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to add jitter to response latency.
// Only instantiated when MEM_RANDOM_LATENCY_EN is defined.
module mem_lfsr
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = lfsr_q;
        if (advance_i) begin
            lfsr_d = {lfsr_q[14:0], feedback};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// Behavioural line-memory responder: one outstanding read/write, fixed (or jittered)
// latency, single-cycle mem_ready. Define MEM_RANDOM_LATENCY_EN to add 0..7 random extra cycles.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY   = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready
);

    state_e                 state_q, state_d;
    logic [8:0]             cnt_q, cnt_d;
    logic                   isWrite_q, isWrite_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]      wdata_q, wdata_d;
    logic [LINE_W-1:0]      lineMem_q [2**ADDR_BITS];
    logic [8:0]             latEff;

`ifdef MEM_RANDOM_LATENCY_EN
    logic        accept;
    logic [15:0] lfsrVal;
    logic [12:0] unusedLfsrBits;

    assign accept = (state_q == IDLE) && (mem_read || mem_write);

    mem_lfsr u_lfsr (
        .clk       (clk),
        .rst       (proc_reset),
        .advance_i (accept),
        .lfsr_o    (lfsrVal)
    );

    assign unusedLfsrBits = lfsrVal[15:3];
    assign latEff         = 9'(LATENCY) + {6'd0, lfsrVal[2:0]};
`else
    assign latEff = 9'(LATENCY);
`endif

    // High address bits are deliberately dropped so lines alias modulo 2^ADDR_BITS.
    if (ADDR_BITS < MEM_ADDR_W) begin : g_alias
        logic [MEM_ADDR_W-ADDR_BITS-1:0] unusedAddrBits;
        assign unusedAddrBits = mem_addr[MEM_ADDR_W-1:ADDR_BITS];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isWrite_d = isWrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    isWrite_d = mem_write;
                    addr_d    = mem_addr[ADDR_BITS-1:0];
                    wdata_d   = mem_wdata;
                    if (latEff == 9'd1) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d   = latEff - 9'd2;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isWrite_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isWrite_q <= isWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Storage is never reset; a write commits only on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if ((state_q == RESP) && isWrite_q && !proc_reset) begin
            lineMem_q[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (state_q == RESP) begin
            mem_ready = 1'b1;
            if (!isWrite_q) begin
                mem_rdata = lineMem_q[addr_q];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder (LATENCY=4, ADDR_BITS=8).
// Latency bound widens to [4,11] when MEM_RANDOM_LATENCY_EN is defined.
module tb_mem_responder;

    localparam int LATENCY   = 4;
    localparam int ADDR_BITS = 8;
    localparam int LAT_MIN   = LATENCY;
`ifdef MEM_RANDOM_LATENCY_EN
    localparam int LAT_MAX   = LATENCY + 7;
`else
    localparam int LAT_MAX   = LATENCY;
`endif

    logic         clk;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [127:0] model [256];
    logic [127:0] sbQ [$];

    mem_responder #(
        .LATENCY   (LATENCY),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues one request in the first cycle after the previous response and waits for mem_ready.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [27:0] addr, input logic [127:0] wd);
        logic [127:0] expData;
        logic         seen;
        logic         noisy;
        int           lat;
        @(negedge clk);
        checkOutput({tag, "_idle_ready"}, 128'(mem_ready), 128'd0);
        checkOutput({tag, "_idle_rdata"}, mem_rdata, 128'd0);
        if (wr) begin
            model[addr[7:0]] = wd;
            expData          = '0;
        end else begin
            expData = model[addr[7:0]];
        end
        sbQ.push_back(expData);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        seen  = 1'b0;
        noisy = 1'b0;
        lat   = 0;
        for (int cyc = 1; cyc <= LAT_MAX + 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                mem_addr  = ~addr;
                mem_wdata = ~wd;
            end
            if (mem_ready) begin
                seen = 1'b1;
                lat  = cyc;
                break;
            end
            if (mem_rdata !== 128'd0) noisy = 1'b1;
        end
        checkOutput({tag, "_rdata_quiet"}, 128'(noisy), 128'd0);
        checkOutput({tag, "_ready_seen"}, 128'(seen), 128'd1);
`ifdef MEM_RANDOM_LATENCY_EN
        checkOutput({tag, "_latency_in_range"}, 128'((lat >= LAT_MIN) && (lat <= LAT_MAX)), 128'd1);
`else
        checkOutput({tag, "_latency"}, 128'(lat), 128'(LATENCY));
`endif
        expData = sbQ.pop_front();
        if (seen) checkOutput({tag, "_rdata"}, mem_rdata, expData);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic seenReady;
        logic [127:0] d;
        clk        = 1'b0;
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        #1;
        checkOutput("reset_ready", 128'(mem_ready), 128'd0);
        checkOutput("reset_rdata", mem_rdata, 128'd0);
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;

        applyStimulus("wr5", 1'b0, 1'b1, 28'h5, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        applyStimulus("rd5", 1'b1, 1'b0, 28'h5, 128'h0);

        applyStimulus("wr33", 1'b0, 1'b1, 28'h33, 128'hDEAD_BEEF_0000_3333);
        applyStimulus("wr12", 1'b0, 1'b1, 28'h12, 128'h1212_1212_1212);
        applyStimulus("rd33", 1'b1, 1'b0, 28'h33, 128'h0);

        applyStimulus("both7", 1'b1, 1'b1, 28'h7, 128'hFF);
        applyStimulus("rd7", 1'b1, 1'b0, 28'h7, 128'h0);

        applyStimulus("wr3", 1'b0, 1'b1, 28'h3, 128'hAA);

        // Write aborted by reset while the request is still counting down.
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h3;
        mem_wdata = 128'hBB;
        repeat (2) @(negedge clk);
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        #1;
        checkOutput("abort_busy_ready", 128'(mem_ready), 128'd0);
        @(negedge clk);
        proc_reset = 1'b0;
        seenReady  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (mem_ready) seenReady = 1'b1;
        end
        checkOutput("abort_busy_no_ready", 128'(seenReady), 128'd0);
        applyStimulus("rd3_after_busy_abort", 1'b1, 1'b0, 28'h3, 128'h0);

        // Write aborted by reset while mem_ready is already high.
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h3;
        mem_wdata = 128'hCC;
        seenReady = 1'b0;
        for (int cyc = 1; cyc <= LAT_MAX + 4; cyc++) begin
            @(negedge clk);
            if (mem_ready) begin
                seenReady = 1'b1;
                break;
            end
        end
        checkOutput("abort_resp_ready_seen", 128'(seenReady), 128'd1);
        checkOutput("abort_resp_rdata_write", mem_rdata, 128'd0);
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        #1;
        checkOutput("abort_resp_ready_cleared", 128'(mem_ready), 128'd0);
        @(negedge clk);
        proc_reset = 1'b0;
        applyStimulus("rd3_after_resp_abort", 1'b1, 1'b0, 28'h3, 128'h0);

        applyStimulus("wr100", 1'b0, 1'b1, 28'h100, 128'h5A);
        applyStimulus("rd000", 1'b1, 1'b0, 28'h000, 128'h0);
        checkOutput("alias_model", model[8'h00], 128'h5A);

        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus("fill", 1'b0, 1'b1, 28'(i * 16 + 9) | 28'hA00_0000, d);
        end
        for (int k = 0; k < 100; k++) begin
            applyStimulus("sweep", 1'b1, 1'b0, 28'(((k * 7) % 16) * 16 + 9), 128'h0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
